// File: rtl/pb_conditioner.sv
// Pushbutton conditioner: per-button synchronizer and tick-sampled debouncer.
// Also produces edge pulses and a count of the pressed note keys.

module pb_lane #(
    parameter int STABLE_SAMPLES = 4
) (
    input  logic clk,
    input  logic n_rst,
    input  logic tick,
    input  logic raw,
    output logic clean,
    output logic rise,
    output logic fall
);
    logic [1:0]                sync;
    logic [STABLE_SAMPLES-1:0] hist;
    logic [STABLE_SAMPLES-1:0] hist_nxt;

    // Acceptance looks at the history as it will be after this tick's shift
    assign hist_nxt = {hist[STABLE_SAMPLES-2:0], sync[1]};

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sync  <= '0;
            hist  <= '0;
            clean <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            sync <= {sync[0], raw};
            rise <= 1'b0;
            fall <= 1'b0;
            if (tick) begin
                hist <= hist_nxt;
                if ((&hist_nxt) && !clean) begin
                    clean <= 1'b1;
                    rise  <= 1'b1;
                end else if (!(|hist_nxt) && clean) begin
                    clean <= 1'b0;
                    fall  <= 1'b1;
                end
            end
        end
    end
endmodule

module pb_conditioner #(
    parameter int NUM_PB         = 15,
    parameter int TICK_DIV       = 10000,
    parameter int STABLE_SAMPLES = 4
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic [NUM_PB-1:0] pb_raw,
    output logic [NUM_PB-1:0] pb_clean,
    output logic [NUM_PB-1:0] pb_rise,
    output logic [NUM_PB-1:0] pb_fall,
    output logic [3:0]        num_pressed
);
    localparam int CW = $clog2(TICK_DIV);
    localparam int NK = (NUM_PB < 12) ? NUM_PB : 12;

    logic [CW-1:0] cnt;
    logic          tick;

    assign tick = (cnt == CW'(TICK_DIV - 1));

    // Free-running sample divider, shared by all buttons
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) cnt <= '0;
        else        cnt <= tick ? '0 : cnt + 1'b1;
    end

    for (genvar i = 0; i < NUM_PB; i++) begin : g_lane
        pb_lane #(.STABLE_SAMPLES(STABLE_SAMPLES)) u_lane (
            .clk   (clk),
            .n_rst (n_rst),
            .tick  (tick),
            .raw   (pb_raw[i]),
            .clean (pb_clean[i]),
            .rise  (pb_rise[i]),
            .fall  (pb_fall[i])
        );
    end

    // Only the low twelve buttons are note keys; mode/octave are not counted
    always_comb begin
        num_pressed = '0;
        for (int i = 0; i < NK; i++) num_pressed = num_pressed + 4'(pb_clean[i]);
    end
endmodule

// File: tb/tb_pb_conditioner.sv
// Bench for pb_conditioner: directed scenarios plus random toggling, checked
// each cycle against a run-length debounce model.

module tb_pb_conditioner;
    localparam int NPB = 15;
    localparam int TD  = 4;
    localparam int SS  = 3;

    logic           clk;
    logic           n_rst;
    logic [NPB-1:0] pb_raw;
    logic [NPB-1:0] pb_clean, pb_rise, pb_fall;
    logic [3:0]     num_pressed;

    int total = 0;
    int bad   = 0;

    pb_conditioner #(.NUM_PB(NPB), .TICK_DIV(TD), .STABLE_SAMPLES(SS)) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .pb_raw      (pb_raw),
        .pb_clean    (pb_clean),
        .pb_rise     (pb_rise),
        .pb_fall     (pb_fall),
        .num_pressed (num_pressed)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model: raw seen two edges late; every TD-th edge since reset is a sample;
    // a level is accepted once SS consecutive samples agree on it.
    logic [NPB-1:0] m_clean, m_rise, m_fall, m_last;
    int             m_run [NPB];
    int             m_edges;
    logic [NPB-1:0] m_dly [$];

    task automatic m_reset();
        m_clean = '0; m_rise = '0; m_fall = '0; m_last = '0;
        for (int i = 0; i < NPB; i++) m_run[i] = 0;
        m_edges = 0;
        m_dly.delete();
        m_dly.push_back('0);
        m_dly.push_back('0);
    endtask

    task automatic m_edge(input logic [NPB-1:0] raw);
        logic [NPB-1:0] v;
        m_edges++;
        m_dly.push_back(raw);
        v = m_dly.pop_front();
        m_rise = '0;
        m_fall = '0;
        if (m_edges % TD == 0) begin
            for (int i = 0; i < NPB; i++) begin
                if (v[i] == m_last[i]) m_run[i]++;
                else begin m_last[i] = v[i]; m_run[i] = 1; end
                if (m_run[i] >= SS && v[i] != m_clean[i]) begin
                    m_clean[i] = v[i];
                    if (v[i]) m_rise[i] = 1'b1;
                    else      m_fall[i] = 1'b1;
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all();
        chk("clean", 32'(pb_clean), 32'(m_clean));
        chk("rise",  32'(pb_rise),  32'(m_rise));
        chk("fall",  32'(pb_fall),  32'(m_fall));
        chk("num_pressed", 32'(num_pressed), $countones(m_clean[11:0]));
        chk("rise_fall_overlap", 32'(pb_rise & pb_fall), 32'h0);
    endtask

    task automatic cyc();
        if (n_rst) m_edge(pb_raw);
        @(posedge clk);
        #1;
        chk_all();
    endtask

    task automatic settle(input logic [NPB-1:0] v);
        pb_raw = v;
        for (int k = 0; k < 20; k++) cyc();
    endtask

    initial begin
        int lat, nr, nf;
        bit seen;

        // Reset held with all buttons pressed
        n_rst  = 1'b0;
        pb_raw = 15'h7FFF;
        m_reset();
        #1;
        chk("rst_clean_async", 32'(pb_clean), 32'h0);
        chk("rst_num_async", 32'(num_pressed), 32'h0);
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("rst_rise", 32'(pb_rise), 32'h0);
            chk("rst_fall", 32'(pb_fall), 32'h0);
        end
        n_rst = 1'b1;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            cyc();
            if (pb_clean != '0 && lat == 0) lat = k;
        end
        chk("post_rst_min_latency", 32'(lat >= 2 + 2 * TD + 1), 32'h1);
        chk("post_rst_all_clean", 32'(pb_clean), 32'h7FFF);

        // Clean press and release of button 0
        settle('0);
        pb_raw = 15'h0001;
        lat = 0; nr = 0;
        for (int k = 1; k <= 20; k++) begin
            cyc();
            if (pb_rise[0]) nr++;
            if (pb_clean[0] && lat == 0) lat = k;
        end
        chk("press_latency_window", 32'(lat >= 11 && lat <= 2 + SS * TD), 32'h1);
        chk("press_rise_count", 32'(nr), 32'h1);
        chk("press_num", 32'(num_pressed), 32'h1);
        pb_raw = '0;
        nf = 0;
        for (int k = 1; k <= 20; k++) begin
            cyc();
            if (pb_fall[0]) nf++;
        end
        chk("release_fall_count", 32'(nf), 32'h1);
        chk("release_num", 32'(num_pressed), 32'h0);

        // Bounce on button 3: flips every 5 cycles never span 3 samples
        nr = 0; nf = 0;
        for (int p = 0; p < 8; p++) begin
            pb_raw[3] = (p % 2 == 0);
            for (int k = 0; k < 5; k++) begin
                cyc();
                if (pb_rise[3]) nr++;
                if (pb_fall[3]) nf++;
            end
        end
        chk("bounce_clean", 32'(pb_clean[3]), 32'h0);
        chk("bounce_rise", 32'(nr), 32'h0);
        chk("bounce_fall", 32'(nf), 32'h0);
        pb_raw[3] = 1'b1;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            cyc();
            if (pb_clean[3] && lat == 0) lat = k;
        end
        chk("bounce_hold_latency", 32'(lat >= 1 && lat <= 14), 32'h1);

        // All twelve note keys at once
        settle('0);
        pb_raw = 15'h0FFF;
        seen = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            cyc();
            if (pb_clean != '0 && !seen) begin
                seen = 1'b1;
                chk("simul_clean", 32'(pb_clean), 32'h0FFF);
                chk("simul_rise", 32'(pb_rise), 32'h0FFF);
                chk("simul_num", 32'(num_pressed), 32'd12);
            end
        end
        chk("simul_seen", 32'(seen), 32'h1);

        // Mode/octave buttons are excluded from the count
        settle(15'h7000);
        chk("mode_clean", 32'(pb_clean), 32'h7000);
        chk("mode_num", 32'(num_pressed), 32'h0);

        // Reset mid-debounce discards partial history
        settle('0);
        pb_raw = 15'h0020;
        for (int k = 0; k < 6; k++) cyc();
        n_rst = 1'b0;
        #1;
        m_reset();
        chk("midrst_clean", 32'(pb_clean[5]), 32'h0);
        cyc();
        n_rst = 1'b1;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            cyc();
            if (pb_clean[5] && lat == 0) lat = k;
        end
        chk("midrst_latency_window", 32'(lat >= 2 + 2 * TD + 1 && lat <= 2 + SS * TD), 32'h1);

        // Random toggling against the model
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 5) == 0)
                pb_raw = pb_raw ^ (15'h1 << $urandom_range(0, NPB - 1));
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
